// File: rtl/des_key_scheduler.sv
// Iterative DES key schedule: one PC-2 round key per rk_valid/rk_ready handshake, encrypt or decrypt order.
// Optional build macro DES_KEY_PARITY_CHECK_EN rejects keys whose bytes are not odd parity.
module des_key_scheduler #(
  parameter bit HOLD_KEY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        replay,
  input  logic        abort,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        last_round,
  output logic        busy,
  output logic        parity_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Bit r set: round r+1 uses a 2-bit left shift (otherwise 1).
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [5:0] src;
    pc1 = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      src = 6'(64 - PC1[i]);
      pc1[55 - i] = k[src];
    end
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [5:0] src;
    pc2 = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      src = 6'(56 - PC2[i]);
      pc2[47 - i] = cd[src];
    end
  endfunction

  function automatic logic [55:0] rotl(input logic [55:0] cd, input logic two);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    rotl = two ? {c[25:0], c[27:26], d[25:0], d[27:26]}
               : {c[26:0], c[27],    d[26:0], d[27]};
  endfunction

  function automatic logic [55:0] rotr(input logic [55:0] cd, input logic two);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    rotr = two ? {c[1:0], c[27:2], d[1:0], d[27:2]}
               : {c[0],   c[27:1], d[0],   d[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [55:0] cd_q, hold_q, key_pc1, load_src;
  logic [3:0]  idx_q, idx_inc;
  logic        dec_q;
  logic        load_key, load_replay, advance, key_ok, key_bad;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr_q;

  always_comb begin
    key_ok = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!(^key_in[i*8 +: 8])) key_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= key_bad;
  end

  assign parity_err = perr_q;
`else
  assign key_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign key_ready  = (state_q == IDLE) || (state_q == DONE);
  assign rk_valid   = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign round_key  = pc2(cd_q);
  assign round_idx  = idx_q;
  assign last_round = (state_q == RUN) && (dec_q ? (idx_q == 4'd0) : (idx_q == 4'd15));
  assign key_pc1    = pc1(key_in);
  assign load_src   = load_key ? key_pc1 : hold_q;
  assign idx_inc    = idx_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort overrides everything, including a key accept or handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    load_key    = 1'b0;
    load_replay = 1'b0;
    advance     = 1'b0;
    key_bad     = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (key_valid) begin
            if (key_ok) begin
              load_key = 1'b1;
              state_d  = RUN;
            end else begin
              key_bad = 1'b1;
              state_d = IDLE;
            end
          end else if (state_q == DONE && replay && HOLD_KEY) begin
            load_replay = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (last_round) state_d = HOLD_KEY ? DONE : IDLE;
            else            advance = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // cd_q always holds C/D for the key being presented; decrypt starts at C16/D16 == PC-1 value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q   <= '0;
      hold_q <= '0;
      idx_q  <= '0;
      dec_q  <= 1'b0;
    end else if (load_key || load_replay) begin
      cd_q  <= decrypt ? load_src : rotl(load_src, 1'b0);
      idx_q <= decrypt ? 4'd15 : 4'd0;
      dec_q <= decrypt;
      if (load_key && HOLD_KEY) hold_q <= key_pc1;
    end else if (advance) begin
      if (dec_q) begin
        cd_q  <= rotr(cd_q, SHIFT2[idx_q]);
        idx_q <= idx_q - 4'd1;
      end else begin
        cd_q  <= rotl(cd_q, SHIFT2[idx_inc]);
        idx_q <= idx_inc;
      end
    end
  end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler: encrypt/decrypt order, backpressure, replay, abort, async reset, parity.
module tb_des_key_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        replay = 1'b0;
  logic        abort = 1'b0;
  logic        rk_ready = 1'b0;

  logic        key_ready, rk_valid, last_round, busy, parity_err;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        key_ready_nh, rk_valid_nh, last_round_nh, busy_nh, parity_err_nh;
  logic [47:0] round_key_nh;
  logic [3:0]  round_idx_nh;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic [47:0] exp_k [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  des_key_scheduler #(.HOLD_KEY(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .decrypt(decrypt), .replay(replay), .abort(abort),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
    .round_idx(round_idx), .last_round(last_round), .busy(busy),
    .parity_err(parity_err));

  des_key_scheduler #(.HOLD_KEY(1'b0)) u_dut_nh (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready_nh),
    .key_in(key_in), .decrypt(decrypt), .replay(replay), .abort(abort),
    .rk_valid(rk_valid_nh), .rk_ready(rk_ready), .round_key(round_key_nh),
    .round_idx(round_idx_nh), .last_round(last_round_nh), .busy(busy_nh),
    .parity_err(parity_err_nh));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    check({tag, "_rk_valid"},  64'(rk_valid),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  task automatic load(input logic [63:0] k, input logic dec);
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = k;
    decrypt   = dec;
  endtask

  // Consumes stop_at keys, checking every presented key (stalled cycles included) against the table.
  task automatic consume(input logic dec, input bit rnd, input int unsigned stop_at, input bit chk_nh);
    int unsigned n = 0;
    int unsigned cyc = 0;
    int unsigned e;
    while (n < stop_at) begin
      @(negedge clk);
      key_valid = 1'b0;
      replay    = 1'b0;
      if (cyc == 200) begin
        check("timeout_handshakes", 64'(n), 64'(stop_at));
        return;
      end
      cyc++;
      e = dec ? 15 - n : n;
      check("rk_valid",      64'(rk_valid),   64'd1);
      check("round_key",     64'(round_key),  64'(exp_k[e]));
      check("round_idx",     64'(round_idx),  64'(e));
      check("last_round",    64'(last_round), 64'(n == 15));
      check("key_ready_run", 64'(key_ready),  64'd0);
      check("parity_err_run", 64'(parity_err), 64'd0);
      if (chk_nh) check("nh_rk_valid", 64'(rk_valid_nh), 64'd0);
      if (n == 3 && !rnd && !chk_nh) begin
        key_valid = 1'b1;
        key_in    = 64'h0123456789ABCDEF;
      end
      rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rk_ready) n++;
    end
  endtask

  task automatic full(input logic dec, input bit rnd, input bit chk_nh);
    consume(dec, rnd, 16, chk_nh);
    @(negedge clk);
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    check_idle_outputs("after_sched");
    check("after_sched_last", 64'(last_round), 64'd0);
    if (chk_nh) check("nh_after_rk_valid", 64'(rk_valid_nh), 64'd0);
  endtask

  initial begin
    #3;
    check_idle_outputs("reset");
    check("reset_round_key", 64'(round_key),  64'd0);
    check("reset_round_idx", 64'(round_idx),  64'd0);
    check("reset_last",      64'(last_round), 64'd0);
    check("reset_parity",    64'(parity_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    load(KEY, 1'b0);
    full(1'b0, 1'b0, 1'b0);

    load(KEY, 1'b1);
    full(1'b1, 1'b0, 1'b0);

    load(KEY, 1'b0);
    full(1'b0, 1'b1, 1'b0);

    // Replay from DONE; the HOLD_KEY=0 instance sits in IDLE and must ignore it.
    @(negedge clk);
    replay  = 1'b1;
    decrypt = 1'b1;
    full(1'b1, 1'b0, 1'b1);

    // Abort while round 5 is presented, with a handshake in the same cycle.
    load(KEY, 1'b0);
    consume(1'b0, 1'b0, 5, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    check("abort_pre_idx", 64'(round_idx), 64'd5);
    check("abort_pre_key", 64'(round_key), 64'(exp_k[5]));
    abort    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("abort");
    replay  = 1'b1;
    decrypt = 1'b0;
    @(negedge clk);
    replay = 1'b0;
    check("abort_replay_rk_valid", 64'(rk_valid), 64'd0);
    @(negedge clk);
    check("abort_replay_rk_valid2", 64'(rk_valid), 64'd0);

    // Async reset while round 9 is presented, checked between clock edges.
    load(KEY, 1'b0);
    consume(1'b0, 1'b0, 9, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    check("arst_pre_idx", 64'(round_idx), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    check("arst_round_key", 64'(round_key),  64'd0);
    check("arst_round_idx", 64'(round_idx),  64'd0);
    check("arst_last",      64'(last_round), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DES_KEY_PARITY_CHECK_EN
    load(64'h0000000000000000, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    check("perr_pulse",    64'(parity_err), 64'd1);
    check("perr_rk_valid", 64'(rk_valid),   64'd0);
    @(negedge clk);
    check("perr_clear",     64'(parity_err), 64'd0);
    check_idle_outputs("perr_after");
`endif

    load(KEY, 1'b0);
    full(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/des_key_scheduler.md
Name: des_key_scheduler

Overview:
- Iterative DES key schedule controller; produces one 48-bit round key per handshake.
- Replaces a 16-copy combinational schedule with a single rotate/PC-2 stage plus an FSM.
- Sits between the key-load interface and the iterative DES round datapath, which consumes keys in encrypt order (K1..K16) or decrypt order (K16..K1).

Parameters:
- HOLD_KEY, 1, 1: retain the PC-1 key after a schedule so `replay` restarts it without reloading; 0: `replay` ignored.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `key_valid`  in  1  new key offered
- `key_ready`  out  1  scheduler accepts key
- `key_in`  in  64  DES key; FIPS 46-3 bit n = `key_in[64-n]`, parity bits included
- `decrypt`  in  1  sampled with key/replay; 1 = emit K16 first
- `replay`  in  1  restart last schedule (HOLD_KEY=1 only)
- `abort`  in  1  synchronous; drop current schedule
- `rk_valid`  out  1  `round_key` valid
- `rk_ready`  in  1  datapath consumes round key
- `round_key`  out  48  FIPS bit n = `round_key[48-n]`
- `round_idx`  out  4  DES round number minus 1 of key presented (0..15)
- `last_round`  out  1  high with the 16th key of a schedule
- `busy`  out  1  schedule in progress
- `parity_err`  out  1  see Optional Feature; 0 when the feature is compiled out

Behaviour:
- Reset: all outputs 0 except `key_ready`=1; FSM=IDLE; C/D, held key and counter cleared.
- States:
  - IDLE: `key_ready`=1.
  - RUN: `rk_valid`=1, `busy`=1.
  - DONE: `key_ready`=1; replay allowed.
- Key accept: `key_valid`&`key_ready` in cycle T.
  - PC-1 is applied into C/D registers.
  - First rotation is applied combinationally: left by 1 (encrypt) or 0 (decrypt).
  - T+1: `rk_valid`=1, `round_key`=PC-2(C,D), `round_idx` = 0 (encrypt) or 15 (decrypt).
- Advance: on `rk_valid`&`rk_ready`, next cycle presents the next key.
  - Encrypt: left rotate by schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 indexed by next round; `round_idx` increments.
  - Decrypt: right rotate by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (schedule reversed, excluding round 1's shift); `round_idx` decrements.
  - Zero-bubble: keys can be consumed every cycle.
- Stall: `rk_valid` high and `rk_ready` low holds `round_key`, `round_idx` and `last_round` stable.
- Completion: the handshake with `last_round`=1 moves the FSM to DONE (HOLD_KEY=1) or IDLE (HOLD_KEY=0). `rk_valid` drops next cycle.
- Rotation wrap: C and D are 28-bit independent rotators. Encrypt ends with a total left shift of 28, so C/D return to the PC-1 value.
- Replay (DONE, HOLD_KEY=1): `replay`=1 restarts from the held PC-1 value with a freshly sampled `decrypt`; same latency as a load.
- Key and replay together: if `key_valid` and `replay` are both high in DONE, the new key wins.
- Key arriving in RUN: `key_ready`=0, so it is not accepted.
- `abort`: FSM goes to IDLE next cycle; `rk_valid` and `busy` drop; held key invalidated; highest priority, including over a same-cycle handshake.
- Asynchronous reset mid-schedule returns immediately to reset values.

Optional Feature:
- Macro: `DES_KEY_PARITY_CHECK_EN`.
- Defined:
  - On accept, each key byte must have odd parity.
  - Any failing byte: key discarded, FSM stays IDLE (or drops to IDLE from DONE, invalidating the held key).
  - `parity_err` pulses 1 for one cycle (T+1); no round keys are emitted.
- Undefined: parity bits ignored; `parity_err` tied 0.

Test Plan:
- Encrypt, `rk_ready`=1: load 64'h133457799BBCDFF1 with `decrypt`=0 -> T+1 `round_key`=48'h1B02EFFC7072, `round_idx`=0. 16 consecutive cycles; 16th = 48'hCB3D8B0E17F5 with `last_round`=1; `key_ready`=1 at T+17.
- Decrypt: same key with `decrypt`=1 -> first key 48'hCB3D8B0E17F5, `round_idx`=15; last key 48'h1B02EFFC7072, `round_idx`=0.
- Backpressure: random `rk_ready` pattern -> `round_key` and `round_idx` stable while stalled; sequence identical to the encrypt test.
- Replay: after encrypt completes, pulse `replay` with `decrypt`=1 -> decrypt sequence matches with no reload. With HOLD_KEY=0 -> no `rk_valid`.
- Abort/reset: `abort` at round 5 -> `rk_valid`=0 next cycle; `replay` ignored. Async `rst_n` low at round 9 -> all outputs at reset values without waiting for a clock edge.
- Parity (macro defined): load 64'h0000000000000000 -> `parity_err`=1 at T+1, no `rk_valid`. 64'h133457799BBCDFF1 -> `parity_err`=0 and normal schedule.
